echo_selftest_master: RTL and testbench

ECHO_SELFTEST_MASTER -- requirements
Module: echo_selftest_master

---
 rtl/echo_selftest_master_pkg.sv | 30 +++
 rtl/echo_selftest_master.sv | 171 +++++++++++++++++
 tb/tb_echo_selftest_master.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/echo_selftest_master_pkg.sv
// Shared definitions for the echo self-test master: FSM encoding, AXI response
// code and the fixed test-vector table.
package echo_selftest_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WAIT_B,
    ST_READ,
    ST_WAIT_R,
    ST_NEXT,
    ST_FIN
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         NUM_VECTORS = 4;

  // Entry 0 sits in the least-significant slot, so VEC_TABLE[i] is vector i.
  localparam logic [NUM_VECTORS-1:0][31:0] VEC_TABLE = {
    32'hBEEF_0011,
    32'hDEAD_0011,
    32'hABCD_0001,
    32'h0101_FFFF
  };

  function automatic logic [31:0] vector_at(input logic [1:0] idx);
    return VEC_TABLE[idx];
  endfunction

endpackage

// File: rtl/echo_selftest_master.sv
// AXI4-Lite self-test master: writes four fixed vectors to an echo slave,
// reads each back and reports pass/fail, error count and first failing index.
//
// state   | meaning
// IDLE    | waiting for start
// WRITE   | AW and W offered, each dropped on its own handshake
// WAIT_B  | bready high, waiting for write response
// READ    | AR offered
// WAIT_R  | rready high, waiting for read data; vector judged here
// NEXT    | advance index or finish
// FIN     | one-cycle done pulse
module echo_selftest_master
  import echo_selftest_master_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h0000_0000
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_aresetn,

  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [2:0]                        err_count,
  output logic [1:0]                        first_err_idx,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,

  output logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,

  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [2:0]                        m00_axi_arprot,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,

  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  state_t     state, state_next;
  logic [1:0] idx;
  logic       b_err;
  logic       write_done;

  function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] addr_of(input logic [1:0] i);
    return C_M_TARGET_SLAVE_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({i, 2'b00});
  endfunction

  assign m00_axi_awprot = 3'b000;
  assign m00_axi_arprot = 3'b000;
  assign m00_axi_wstrb  = '1;

  // A channel whose valid has already dropped counts as complete.
  assign write_done = (!m00_axi_awvalid || m00_axi_awready) &&
                      (!m00_axi_wvalid  || m00_axi_wready);

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) state <= ST_IDLE;
    else                  state <= state_next;
  end

  always_comb begin
    state_next     = state;
    busy           = 1'b1;
    done           = 1'b0;
    m00_axi_bready = 1'b0;
    m00_axi_rready = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_WRITE;
      end
      ST_WRITE:  if (write_done) state_next = ST_WAIT_B;
      ST_WAIT_B: begin
        m00_axi_bready = 1'b1;
        if (m00_axi_bvalid) state_next = ST_READ;
      end
      ST_READ:   if (m00_axi_arready) state_next = ST_WAIT_R;
      ST_WAIT_R: begin
        m00_axi_rready = 1'b1;
        if (m00_axi_rvalid) state_next = ST_NEXT;
      end
      ST_NEXT:   state_next = (idx == 2'd3) ? ST_FIN : ST_WRITE;
      ST_FIN: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      idx             <= '0;
      b_err           <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_idx   <= '0;
      m00_axi_awvalid <= 1'b0;
      m00_axi_wvalid  <= 1'b0;
      m00_axi_arvalid <= 1'b0;
      m00_axi_awaddr  <= '0;
      m00_axi_wdata   <= '0;
      m00_axi_araddr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx             <= '0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_idx   <= '0;
            m00_axi_awvalid <= 1'b1;
            m00_axi_wvalid  <= 1'b1;
            m00_axi_awaddr  <= addr_of(2'd0);
            m00_axi_wdata   <= vector_at(2'd0);
          end
        end
        ST_WRITE: begin
          if (m00_axi_awready) m00_axi_awvalid <= 1'b0;
          if (m00_axi_wready)  m00_axi_wvalid  <= 1'b0;
        end
        ST_WAIT_B: begin
          if (m00_axi_bvalid) begin
            b_err           <= (m00_axi_bresp != RESP_OKAY);
            m00_axi_arvalid <= 1'b1;
            m00_axi_araddr  <= addr_of(idx);
          end
        end
        ST_READ: begin
          if (m00_axi_arready) m00_axi_arvalid <= 1'b0;
        end
        ST_WAIT_R: begin
          if (m00_axi_rvalid && (b_err || (m00_axi_rresp != RESP_OKAY) ||
                                 (m00_axi_rdata != vector_at(idx)))) begin
            err_count <= err_count + 3'd1;
            if (err_count == 3'd0) first_err_idx <= idx;
          end
        end
        ST_NEXT: begin
          // err_count already includes the last vector, so pass is ready with done.
          if (idx == 2'd3) begin
            pass <= (err_count == 3'd0);
          end else begin
            idx             <= idx + 2'd1;
            m00_axi_awvalid <= 1'b1;
            m00_axi_wvalid  <= 1'b1;
            m00_axi_awaddr  <= addr_of(idx + 2'd1);
            m00_axi_wdata   <= vector_at(idx + 2'd1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_selftest_master.sv
// Bench for echo_selftest_master: reactive echo slave with configurable ready
// delays and fault injection, checked against a vector-level reference model.
module tb_echo_selftest_master;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [2:0]  err_count;
  logic [1:0]  first_err_idx;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'h0;

  always #5 clk = ~clk;

  echo_selftest_master dut (
    .m00_axi_aclk    (clk),
    .m00_axi_aresetn (aresetn),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_idx   (first_err_idx),
    .m00_axi_awaddr  (awaddr),
    .m00_axi_awprot  (awprot),
    .m00_axi_awvalid (awvalid),
    .m00_axi_awready (awready),
    .m00_axi_wdata   (wdata),
    .m00_axi_wstrb   (wstrb),
    .m00_axi_wvalid  (wvalid),
    .m00_axi_wready  (wready),
    .m00_axi_bresp   (bresp),
    .m00_axi_bvalid  (bvalid),
    .m00_axi_bready  (bready),
    .m00_axi_araddr  (araddr),
    .m00_axi_arprot  (arprot),
    .m00_axi_arvalid (arvalid),
    .m00_axi_arready (arready),
    .m00_axi_rdata   (rdata),
    .m00_axi_rresp   (rresp),
    .m00_axi_rvalid  (rvalid),
    .m00_axi_rready  (rready)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] tbl [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};

  // slave configuration, changed between runs by the main sequence
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  bit          rand_dly = 1'b0;
  bit [3:0]    bresp_bad = 4'h0, rresp_bad = 4'h0, rdata_bad = 4'h0;
  logic [31:0] rdata_flip [4] = '{default: 32'h0};

  logic [31:0] aw_log[$], w_log[$], ar_log[$];
  int          proto_err = 0;
  int          done_cnt = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  // Echo slave: decisions at negedge; a handshake seen here completes at the next posedge.
  initial begin : slave
    logic [31:0] mem [4];
    logic [31:0] aw_a, w_d, ar_a, aw_hold, w_hold, ar_hold;
    bit          have_aw, have_w, have_ar, aw_f, w_f, ar_f, b_f, r_f;
    bit          aw_pend, w_pend, ar_pend;
    int          aw_c, w_c, ar_c, aw_d, w_dd, ar_d, vi;
    have_aw = 0; have_w = 0; have_ar = 0;
    aw_f = 0; w_f = 0; ar_f = 0; b_f = 0; r_f = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0;
    aw_c = 0; w_c = 0; ar_c = 0; aw_d = 0; w_dd = 0; ar_d = 0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        have_aw = 0; have_w = 0; have_ar = 0;
        aw_f = 0; w_f = 0; ar_f = 0; b_f = 0; r_f = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        aw_c = 0; w_c = 0; ar_c = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        continue;
      end
      if (aw_f) have_aw = 1;
      if (w_f)  have_w = 1;
      if (ar_f) have_ar = 1;
      if (b_f)  bvalid = 0;
      if (r_f)  rvalid = 0;
      aw_f = 0; w_f = 0; ar_f = 0;
      if (aw_pend && (!awvalid || awaddr !== aw_hold)) proto_err++;
      if (w_pend  && (!wvalid  || wdata  !== w_hold))  proto_err++;
      if (ar_pend && (!arvalid || araddr !== ar_hold)) proto_err++;
      if (have_aw && have_w && !bvalid) begin
        vi = int'((aw_a - BASE) >> 2) & 3;
        mem[vi] = w_d;
        bvalid = 1;
        bresp = bresp_bad[vi] ? 2'b10 : 2'b00;
        have_aw = 0; have_w = 0;
      end
      if (have_ar && !rvalid) begin
        vi = int'((ar_a - BASE) >> 2) & 3;
        rvalid = 1;
        rdata = mem[vi] ^ (rdata_bad[vi] ? rdata_flip[vi] : 32'h0);
        rresp = rresp_bad[vi] ? 2'b10 : 2'b00;
        have_ar = 0;
      end
      if (awvalid && aw_c == 0) aw_d = rand_dly ? int'($urandom_range(0, 3)) : aw_dly;
      if (wvalid  && w_c == 0)  w_dd = rand_dly ? int'($urandom_range(0, 3)) : w_dly;
      if (arvalid && ar_c == 0) ar_d = rand_dly ? int'($urandom_range(0, 3)) : ar_dly;
      awready = awvalid && (aw_c >= aw_d);
      wready  = wvalid  && (w_c  >= w_dd);
      arready = arvalid && (ar_c >= ar_d);
      if (awvalid) aw_c++;
      if (wvalid)  w_c++;
      if (arvalid) ar_c++;
      if (awvalid && awready) begin
        aw_f = 1; aw_a = awaddr; aw_c = 0; aw_log.push_back(awaddr);
        if (awprot !== 3'b000) proto_err++;
      end
      if (wvalid && wready) begin
        w_f = 1; w_d = wdata; w_c = 0; w_log.push_back(wdata);
        if (wstrb !== 4'hF) proto_err++;
      end
      if (arvalid && arready) begin
        ar_f = 1; ar_a = araddr; ar_c = 0; ar_log.push_back(araddr);
        if (arprot !== 3'b000) proto_err++;
      end
      aw_pend = awvalid && !aw_f; aw_hold = awaddr;
      w_pend  = wvalid  && !w_f;  w_hold  = wdata;
      ar_pend = arvalid && !ar_f; ar_hold = araddr;
      b_f = bvalid && bready;
      r_f = rvalid && rready;
    end
  end

  // One complete run; expectations come from the fault masks, vector by vector.
  task automatic run_test(input string tag, input int exp_lat, input int extra_start_at);
    int n, exp_err, exp_first;
    bit found;
    exp_err = 0; exp_first = 0; found = 0;
    for (int i = 0; i < 4; i++) begin
      if (bresp_bad[i] || rresp_bad[i] || (rdata_bad[i] && rdata_flip[i] != 0)) begin
        exp_err++;
        if (!found) begin exp_first = i; found = 1; end
      end
    end
    aw_log.delete(); w_log.delete(); ar_log.delete();
    proto_err = 0; done_cnt = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; n = 1;
    check({tag, ":busy_rise"}, busy, 1);
    check({tag, ":err_clear"}, {err_count, first_err_idx}, 0);
    while (!done && n < 600) begin
      @(negedge clk); n++;
      start = (n == extra_start_at);
    end
    start = 0;
    check({tag, ":done_seen"}, done, 1);
    if (exp_lat > 0) check({tag, ":latency"}, n, exp_lat);
    check({tag, ":pass"}, pass, (exp_err == 0));
    check({tag, ":err_count"}, err_count, exp_err);
    check({tag, ":first_err_idx"}, first_err_idx, exp_first);
    @(negedge clk);
    check({tag, ":busy_fall"}, {busy, done, pass}, {2'b00, (exp_err == 0)});
    repeat (30) @(negedge clk);
    check({tag, ":done_pulses"}, done_cnt, 1);
    check({tag, ":txn_count"}, {aw_log.size(), w_log.size(), ar_log.size()}, {32'd4, 32'd4, 32'd4});
    for (int i = 0; i < 4 && i < aw_log.size() && i < w_log.size() && i < ar_log.size(); i++)
      check($sformatf("%s:txn%0d", tag, i), {aw_log[i], w_log[i], ar_log[i]},
            {BASE + 32'(4 * i), tbl[i], BASE + 32'(4 * i)});
    check({tag, ":protocol"}, proto_err, 0);
  endtask

  initial begin
    int  n;
    bit  quiet;
    #1;
    check("reset_state", {awvalid, wvalid, arvalid, bready, rready, busy, done, pass,
                          err_count, first_err_idx, awaddr, wdata, araddr}, 0);
    repeat (3) @(negedge clk);
    #1 aresetn = 1;

    run_test("zero_wait", 21, 0);

    aw_dly = 3; w_dly = 0;
    run_test("aw_late", 33, 0);
    aw_dly = 0;

    rdata_bad = 4'b0100; rdata_flip[2] = 32'hDEAD0011 ^ 32'hDEAD0010;
    run_test("rdata_bad_v2", 21, 0);
    rdata_bad = 4'b0000;

    bresp_bad = 4'b0010; rresp_bad = 4'b1000;
    run_test("resp_err_v1_v3", 21, 0);
    bresp_bad = 4'b0000; rresp_bad = 4'b0000;

    run_test("start_while_busy", 21, 5);

    @(negedge clk); start = 1;
    @(negedge clk); start = 0; n = 0;
    while (!(awvalid && awaddr == BASE + 32'h4) && n < 100) begin
      @(negedge clk); n++;
    end
    check("rst_mid:awvalid", {awvalid, awaddr}, {1'b1, BASE + 32'h4});
    #1 aresetn = 0;
    #1;
    check("rst_mid:outputs", {awvalid, wvalid, arvalid, bready, rready, busy, done, pass,
                              err_count, first_err_idx, awaddr, wdata, araddr}, 0);
    repeat (3) @(negedge clk);
    #1 aresetn = 1;
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      quiet = quiet | awvalid | wvalid | arvalid | busy;
    end
    check("rst_mid:quiet", quiet, 0);
    run_test("after_reset", 21, 0);

    rand_dly = 1;
    for (int r = 0; r < 6; r++) begin
      bresp_bad = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      rresp_bad = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      rdata_bad = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int i = 0; i < 4; i++) rdata_flip[i] = 32'h1 << $urandom_range(0, 31);
      run_test($sformatf("rand%0d", r), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
